keypad_code_lock: RTL and testbench

KEYPAD_CODE_LOCK -- requirements
Module: keypad_code_lock

---
 rtl/keypad_code_lock.sv | 180 ++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_lock.sv
// rtl/keypad_code_lock.sv - digit-sequence code lock with failure lockout
module keypad_code_lock #(
   parameter int                    CODE_LEN       = 4,
   parameter logic [4*CODE_LEN-1:0] CODE           = 16'h0246,
   parameter int                    MAX_FAILS      = 3,
   parameter int                    UNLOCK_CYCLES  = 500,
   parameter int                    LOCKOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] keys,
   input  logic       clear,
   output logic       unlocked,
   output logic       error,
   output logic       locked_out,
   output logic [2:0] digit_count,
   output logic [1:0] fail_count
);

   localparam int             UW          = $clog2(UNLOCK_CYCLES) + 1;
   localparam int             LW          = $clog2(LOCKOUT_CYCLES) + 1;
   localparam logic [UW-1:0]  UNLOCK_LOAD = UW'(UNLOCK_CYCLES - 1);
   localparam logic [LW-1:0]  LOCK_LOAD   = LW'(LOCKOUT_CYCLES - 1);
   localparam logic [1:0]     FAIL_MAX    = 2'(MAX_FAILS);
   localparam logic [2:0]     LAST_POS    = 3'(CODE_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPEN,
      LOCKOUT
   } state_t;

   state_t                     state_q, state_d;
   logic [9:0]                 keys_q;
   logic [9:0]                 rise;
   logic                       press_ok;
   logic [3:0]                 press_digit;
   logic                       code_match;
   logic [1:0]                 fail_inc;
   logic [CODE_LEN-1:0][3:0]   digits_q, digits_d;
   logic [2:0]                 digit_count_q, digit_count_d;
   logic [1:0]                 fail_count_q, fail_count_d;
   logic                       unlocked_q, unlocked_d;
   logic                       error_q, error_d;
   logic                       locked_out_q, locked_out_d;
   logic [UW-1:0]              unlock_tmr_q, unlock_tmr_d;
   logic [LW-1:0]              lock_tmr_q, lock_tmr_d;

   // A press is a single newly-risen key; multi-key rises are discarded.
   assign rise     = keys & ~keys_q;
   assign press_ok = (rise != '0) && ((rise & (rise - 10'd1)) == '0);

   // Saturating failure increment so the counter never wraps.
   assign fail_inc = (fail_count_q >= FAIL_MAX) ? fail_count_q : fail_count_q + 2'd1;

   // Encode the index of the risen key as the pressed digit.
   always_comb begin
      press_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (rise[i]) press_digit = 4'(i);
      end
   end

   // Position 0 holds the first digit, which lives in the top nibble of CODE.
   always_comb begin
      code_match = 1'b1;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (digits_q[i] != CODE[4*(CODE_LEN-1-i) +: 4]) code_match = 1'b0;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      digits_d      = digits_q;
      digit_count_d = digit_count_q;
      fail_count_d  = fail_count_q;
      unlocked_d    = unlocked_q;
      error_d       = 1'b0;
      locked_out_d  = locked_out_q;
      unlock_tmr_d  = unlock_tmr_q;
      lock_tmr_d    = lock_tmr_q;
      case (state_q)
         IDLE: begin
            if (press_ok && !clear) begin
               digits_d[0]   = press_digit;
               digit_count_d = 3'd1;
               state_d       = (CODE_LEN == 1) ? CHECK : ENTRY;
            end
         end
         ENTRY: begin
            if (clear) begin
               digit_count_d = 3'd0;
               state_d       = IDLE;
            end else if (press_ok) begin
               for (int i = 0; i < CODE_LEN; i++) begin
                  if (3'(i) == digit_count_q) digits_d[i] = press_digit;
               end
               digit_count_d = digit_count_q + 3'd1;
               if (digit_count_q == LAST_POS) state_d = CHECK;
            end
         end
         CHECK: begin
            digit_count_d = 3'd0;
            if (code_match) begin
               state_d      = OPEN;
               unlocked_d   = 1'b1;
               unlock_tmr_d = UNLOCK_LOAD;
               fail_count_d = 2'd0;
            end else begin
               error_d      = 1'b1;
               fail_count_d = fail_inc;
               if (fail_inc >= FAIL_MAX) begin
                  state_d      = LOCKOUT;
                  locked_out_d = 1'b1;
                  lock_tmr_d   = LOCK_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OPEN: begin
            if (clear || unlock_tmr_q == '0) begin
               state_d    = IDLE;
               unlocked_d = 1'b0;
            end else begin
               unlock_tmr_d = unlock_tmr_q - 1'b1;
            end
         end
         LOCKOUT: begin
            if (lock_tmr_q == '0) begin
               state_d      = IDLE;
               locked_out_d = 1'b0;
               fail_count_d = 2'd0;
            end else begin
               lock_tmr_d = lock_tmr_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; keys_q resets high so held keys are not presses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         keys_q        <= 10'h3FF;
         digits_q      <= '0;
         digit_count_q <= 3'd0;
         fail_count_q  <= 2'd0;
         unlocked_q    <= 1'b0;
         error_q       <= 1'b0;
         locked_out_q  <= 1'b0;
         unlock_tmr_q  <= '0;
         lock_tmr_q    <= '0;
      end else begin
         state_q       <= state_d;
         keys_q        <= keys;
         digits_q      <= digits_d;
         digit_count_q <= digit_count_d;
         fail_count_q  <= fail_count_d;
         unlocked_q    <= unlocked_d;
         error_q       <= error_d;
         locked_out_q  <= locked_out_d;
         unlock_tmr_q  <= unlock_tmr_d;
         lock_tmr_q    <= lock_tmr_d;
      end
   end

   assign unlocked    = unlocked_q;
   assign error       = error_q;
   assign locked_out  = locked_out_q;
   assign digit_count = digit_count_q;
   assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// tb/tb_keypad_code_lock.sv - scoreboard bench for keypad_code_lock
module tb_keypad_code_lock;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] keys = 10'h020;
   logic       clear = 1'b0;
   logic       unlocked, error, locked_out;
   logic [2:0] digit_count;
   logic [1:0] fail_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_fail = 0;

   typedef struct {
      bit    is_open;
      int    fails;
      string tag;
   } exp_t;
   exp_t sb[$];

   keypad_code_lock #(
      .UNLOCK_CYCLES (10),
      .LOCKOUT_CYCLES(20)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keys       (keys),
      .clear      (clear),
      .unlocked   (unlocked),
      .error      (error),
      .locked_out (locked_out),
      .digit_count(digit_count),
      .fail_count (fail_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic press(input int d);
      @(negedge clk);
      keys = 10'(1 << d);
      @(negedge clk);
      keys = '0;
   endtask

   task automatic check_result();
      exp_t e;
      int lat, n_unl, n_err, n_lock, bad_dc;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      check({e.tag, "_check_cycle_quiet"}, int'(unlocked | error), 0);
      lat = 0;
      while (!(unlocked || error) && lat < 4) begin
         @(negedge clk);
         lat++;
      end
      check({e.tag, "_latency"}, lat, 1);
      check({e.tag, "_is_open"}, int'(unlocked), int'(e.is_open));
      check({e.tag, "_fail_count"}, int'(fail_count), e.fails);
      check({e.tag, "_digit_count"}, int'(digit_count), 0);
      n_unl = 0; n_err = 0; n_lock = 0; bad_dc = 0;
      for (int k = 0; k < 30; k++) begin
         n_unl  += int'(unlocked);
         n_err  += int'(error);
         n_lock += int'(locked_out);
         if (locked_out && digit_count != 3'd0) bad_dc++;
         keys = (locked_out && (k % 4 == 1)) ? 10'(1 << (k % 10)) : '0;
         @(negedge clk);
      end
      keys = '0;
      check({e.tag, "_unlock_width"}, n_unl, e.is_open ? 10 : 0);
      check({e.tag, "_error_width"}, n_err, e.is_open ? 0 : 1);
      check({e.tag, "_lockout_width"}, n_lock, (!e.is_open && e.fails == 3) ? 20 : 0);
      check({e.tag, "_lockout_presses"}, bad_dc, 0);
      if (!e.is_open && e.fails == 3) begin
         exp_fail = 0;
         check({e.tag, "_fail_after_lockout"}, int'(fail_count), 0);
      end
   endtask

   task automatic enter_code(input logic [15:0] c, input string tag);
      exp_t e;
      e.is_open = (c == 16'h0246);
      if (e.is_open) exp_fail = 0;
      else if (exp_fail < 3) exp_fail++;
      e.fails = exp_fail;
      e.tag   = tag;
      sb.push_back(e);
      for (int i = 0; i < 4; i++) press(int'(c[15-4*i -: 4]));
      check_result();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_unlocked", int'(unlocked), 0);
      check("rst_error", int'(error), 0);
      check("rst_locked_out", int'(locked_out), 0);
      check("rst_digit_count", int'(digit_count), 0);
      check("rst_fail_count", int'(fail_count), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("held_key5_ignored", int'(digit_count), 0);
      keys = '0;
      @(negedge clk);
      press(5);
      check("key5_repress", int'(digit_count), 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_after_key5", int'(digit_count), 0);

      enter_code(16'h0246, "open1");
      enter_code(16'h0247, "wrong1");

      @(negedge clk);
      keys = 10'h003;
      @(negedge clk);
      keys = '0;
      check("multi_rise_ignored", int'(digit_count), 0);

      press(0);
      press(2);
      check("two_digits", int'(digit_count), 2);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_two_digits", int'(digit_count), 0);
      check("clear_keeps_fails", int'(fail_count), exp_fail);

      @(negedge clk);
      keys = 10'h001; clear = 1'b1;
      @(negedge clk);
      keys = '0; clear = 1'b0;
      check("clear_press_idle", int'(digit_count), 0);

      press(0);
      @(negedge clk);
      keys = 10'h004; clear = 1'b1;
      @(negedge clk);
      keys = '0; clear = 1'b0;
      check("clear_press_entry", int'(digit_count), 0);

      enter_code(16'h0246, "open2");
      enter_code(16'h1111, "wrong_a");
      enter_code(16'h0264, "wrong_b");
      enter_code(16'h9999, "wrong_lock");
      enter_code(16'h0246, "open_after_lock");

      press(0); press(2); press(4); press(6);
      @(negedge clk);
      check("open_before_clear", int'(unlocked), 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_in_open", int'(unlocked), 0);
      repeat (2) @(negedge clk);

      enter_code(16'h0247, "wrong_pre_reset");
      press(0); press(2);
      #2 rst_n = 1'b0;
      #1;
      check("midentry_rst_digit_count", int'(digit_count), 0);
      check("midentry_rst_fail_count", int'(fail_count), 0);
      check("midentry_rst_error", int'(error), 0);
      exp_fail = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      press(0); press(2); press(4); press(6);
      repeat (3) @(negedge clk);
      check("open_before_reset", int'(unlocked), 1);
      #2 rst_n = 1'b0;
      #1;
      check("open_rst_unlocked", int'(unlocked), 0);
      check("open_rst_locked_out", int'(locked_out), 0);
      check("open_rst_digit_count", int'(digit_count), 0);
      check("open_rst_fail_count", int'(fail_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_unlocked", int'(unlocked), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
